// File: rtl/serial_io_chain_if.sv
// Pin-side and core-side signals of one serial_io_chain instance.
// The engine uses the slave modport; the core logic or a bench drives the master side.
interface serial_io_chain_if #(
   parameter int OUT_W = 16,
   parameter int IN_W  = 21
);
   logic [OUT_W-1:0] i_Data;
   logic             i_Start;
   logic             i_SerIn;
   logic             o_SerOut;
   logic             o_SerCLK;
   logic             o_OutLatch;
   logic             o_InLatch;
   logic [IN_W-1:0]  o_InData;
   logic             o_Valid;
   logic             o_Changed;
   logic             o_Busy;

   modport master (
      output i_Data, i_Start, i_SerIn,
      input  o_SerOut, o_SerCLK, o_OutLatch, o_InLatch, o_InData, o_Valid, o_Changed, o_Busy
   );

   modport slave (
      input  i_Data, i_Start, i_SerIn,
      output o_SerOut, o_SerCLK, o_OutLatch, o_InLatch, o_InData, o_Valid, o_Changed, o_Busy
   );
endinterface

// File: rtl/serial_io_chain.sv
// Serial engine for 595/165-style chains: shifts an OUT_W word out while an IN_W word
// shifts in, framed by LOAD / SHIFT / COMMIT with a programmable serial clock divider.
module serial_io_chain #(
   parameter int OUT_W      = 16,
   parameter int IN_W       = 21,
   parameter int DIV        = 4,
   parameter int MSB_FIRST  = 1,
   parameter int CONTINUOUS = 1
) (
   input logic               i_CLK,
   input logic               i_RESET,
   serial_io_chain_if.slave  bus
);
   localparam int N  = (OUT_W > IN_W) ? OUT_W : IN_W;
   localparam int PW = $clog2(DIV + 1);
   localparam int BW = $clog2(N + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

   state_t          state;
   logic [PW-1:0]   phase_cnt;
   logic [BW-1:0]   bit_cnt;
   logic            idle_done;
   logic [N-1:0]    out_sr;
   logic [IN_W-1:0] in_sr;

   logic            phase_end;
   logic            next_out;
   logic [N-1:0]    out_sr_shifted;
   logic [N-1:0]    load_word;
   logic [IN_W-1:0] in_sr_next;

   assign phase_end = (phase_cnt == PHASE_LAST);

   // Padding zeros sit on the side that leaves the register first.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      if (MSB_FIRST != 0) begin
         next_out       = out_sr[N-1];
         out_sr_shifted = out_sr << 1;
         load_word      = N'(bus.i_Data);
         in_sr_next     = {in_sr[IN_W-2:0], bus.i_SerIn};
      end else begin
         next_out       = out_sr[0];
         out_sr_shifted = out_sr >> 1;
         load_word      = N'(bus.i_Data) << (N - OUT_W);
         in_sr_next     = {bus.i_SerIn, in_sr[IN_W-1:1]};
      end
   end

   // NOTE: state and registered outputs use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state          <= IDLE;
         phase_cnt      <= '0;
         bit_cnt        <= '0;
         idle_done      <= 1'b0;
         out_sr         <= '0;
         in_sr          <= '0;
         bus.o_SerOut   <= 1'b0;
         bus.o_SerCLK   <= 1'b0;
         bus.o_OutLatch <= 1'b0;
         bus.o_InLatch  <= 1'b0;
         bus.o_InData   <= '0;
         bus.o_Valid    <= 1'b0;
         bus.o_Changed  <= 1'b0;
         bus.o_Busy     <= 1'b0;
      end else begin
         bus.o_Valid   <= 1'b0;
         bus.o_Changed <= 1'b0;
         case (state)
            IDLE: begin
               // The cycle spent in reset does not count as the one-cycle IDLE dwell.
               if ((CONTINUOUS != 0) ? idle_done : bus.i_Start) begin
                  state         <= LOAD;
                  phase_cnt     <= '0;
                  bit_cnt       <= '0;
                  idle_done     <= 1'b0;
                  out_sr        <= load_word;
                  bus.o_InLatch <= 1'b1;
                  bus.o_Busy    <= 1'b1;
               end else begin
                  idle_done <= 1'b1;
               end
            end
            LOAD: begin
               if (phase_end) begin
                  state         <= SHIFT;
                  phase_cnt     <= '0;
                  out_sr        <= out_sr_shifted;
                  bus.o_SerOut  <= next_out;
                  bus.o_SerCLK  <= 1'b0;
                  bus.o_InLatch <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            SHIFT: begin
               if (!phase_end) begin
                  phase_cnt <= phase_cnt + PW'(1);
               end else begin
                  phase_cnt <= '0;
                  if (!bus.o_SerCLK) begin
                     in_sr        <= in_sr_next;
                     bus.o_SerCLK <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     state          <= COMMIT;
                     bus.o_SerCLK   <= 1'b0;
                     bus.o_OutLatch <= 1'b1;
                     bus.o_InData   <= in_sr;
                     bus.o_Valid    <= 1'b1;
                     bus.o_Changed  <= (in_sr != bus.o_InData);
                  end else begin
                     bit_cnt      <= bit_cnt + BW'(1);
                     out_sr       <= out_sr_shifted;
                     bus.o_SerOut <= next_out;
                     bus.o_SerCLK <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               if (phase_end) begin
                  state          <= IDLE;
                  phase_cnt      <= '0;
                  idle_done      <= 1'b1;
                  bus.o_OutLatch <= 1'b0;
                  bus.o_Busy     <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
